// File: rtl/vrb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vrb_pkg
// Brief    : Shared types and elaboration helpers for vector_register_bank.
// Revision : 1.0 - initial release
// ============================================================================
package vrb_pkg;

  // Loader sequencing: collect beats, then spend one cycle committing.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } ld_state_e;

  // Number of bus beats needed to fill one register.
  function automatic int beats(input int reg_w, input int bus_w);
    return reg_w / bus_w;
  endfunction

  // Legal configurations: power-of-two register count of at least two, and a
  // register width that splits into two or more whole bus beats.
  function automatic bit params_ok(input int num_regs, input int reg_w,
                                   input int bus_w);
    bit ok;
    ok = 1'b1;
    if (num_regs < 2) ok = 1'b0;
    if ((num_regs & (num_regs - 1)) != 0) ok = 1'b0;
    if (bus_w <= 0) ok = 1'b0;
    else begin
      if ((reg_w % bus_w) != 0) ok = 1'b0;
      if ((reg_w / bus_w) < 2) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vector_register_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_register_bank_if
// Brief    : Direct-write, beat-load and read-out signals of the register bank.
// Revision : 1.0 - initial release
// ============================================================================
interface vector_register_bank_if #(
  parameter int NUM_REGS = 4,
  parameter int REG_W    = 512,
  parameter int BUS_W    = 64,
  parameter int AW       = $clog2(NUM_REGS)
);
  logic                      wr_en;
  logic                      wr_wide;
  logic [AW-1:0]             wr_addr;
  logic [2*REG_W-1:0]        wr_data;
  logic                      wr_err;
  logic                      ld_valid;
  logic                      ld_ready;
  logic [AW-1:0]             ld_addr;
  logic [BUS_W-1:0]          ld_data;
  logic                      ld_done;
  logic [NUM_REGS-1:0]       reg_valid;
  logic [NUM_REGS*REG_W-1:0] regs_out;

  modport master (
    output wr_en, wr_wide, wr_addr, wr_data, ld_valid, ld_addr, ld_data,
    input  wr_err, ld_ready, ld_done, reg_valid, regs_out
  );

  modport slave (
    input  wr_en, wr_wide, wr_addr, wr_data, ld_valid, ld_addr, ld_data,
    output wr_err, ld_ready, ld_done, reg_valid, regs_out
  );
endinterface
`default_nettype wire

// File: rtl/vrb_loader.sv
`default_nettype none
// ============================================================================
// Module   : vrb_loader
// Brief    : Beat-serial register loader: assembles BEATS narrow beats into a
//            shadow buffer and requests a one-cycle commit to the target.
// Revision : 1.0 - initial release
// ============================================================================
module vrb_loader
  import vrb_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int REG_W    = 512,
  parameter int BUS_W    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_valid,
  input  logic [$clog2(NUM_REGS)-1:0] ld_addr,
  input  logic [BUS_W-1:0]            ld_data,
  output logic                        ld_ready,
  output logic                        ld_done,
  output logic                        commit_en,
  output logic [$clog2(NUM_REGS)-1:0] commit_addr,
  output logic [REG_W-1:0]            commit_data,
  output logic                        clr_valid_en,
  output logic [$clog2(NUM_REGS)-1:0] clr_valid_addr
);
  localparam int AW    = $clog2(NUM_REGS);
  localparam int BEATS = beats(REG_W, BUS_W);
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  ld_state_e        state_q;
  logic [CW-1:0]    count_q;
  logic [REG_W-1:0] shadow_q;
  logic [AW-1:0]    target_q;
  logic             ld_done_q;

  // Loader FSM with beat counter, shadow buffer, target latch and done pulse.
  // ld_ready is high in IDLE and FILL, so ld_valid alone means acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      shadow_q  <= '0;
      target_q  <= '0;
      ld_done_q <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ld_valid) begin
            target_q             <= ld_addr;
            shadow_q[0 +: BUS_W] <= ld_data;
            count_q              <= CW'(1);
            state_q              <= FILL;
          end
        end
        FILL: begin
          if (ld_valid) begin
            shadow_q[int'(count_q)*BUS_W +: BUS_W] <= ld_data;
            count_q <= count_q + CW'(1);
            if (count_q == LAST_BEAT) begin
              state_q <= COMMIT;
            end
          end
        end
        COMMIT: begin
          count_q   <= '0;
          ld_done_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake and commit request are pure decodes of registered state.
  assign ld_ready       = (state_q != COMMIT);
  assign ld_done        = ld_done_q;
  assign commit_en      = (state_q == COMMIT);
  assign commit_addr    = target_q;
  assign commit_data    = shadow_q;
  // The first accepted beat invalidates the target register until commit.
  assign clr_valid_en   = (state_q == IDLE) && ld_valid;
  assign clr_valid_addr = ld_addr;

endmodule
`default_nettype wire

// File: rtl/vector_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : vector_register_bank
// Brief    : Parametrised operand register file with narrow/wide direct
//            writes, a beat-serial loader and per-register valid flags.
// Revision : 1.0 - initial release
// ============================================================================
module vector_register_bank
  import vrb_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int REG_W    = 512,
  parameter int BUS_W    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  vector_register_bank_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);

  // Reject illegal geometries at elaboration.
  generate
    if (!params_ok(NUM_REGS, REG_W, BUS_W)) begin : g_param_check
      $error("vector_register_bank: illegal NUM_REGS/REG_W/BUS_W combination");
    end
  endgenerate

  logic [REG_W-1:0]    regs_q [NUM_REGS];
  logic [REG_W-1:0]    regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] reg_valid_q;
  logic [NUM_REGS-1:0] reg_valid_d;
  logic                wr_err_q;
  logic                wr_err_d;

  logic                commit_en;
  logic [AW-1:0]       commit_addr;
  logic [REG_W-1:0]    commit_data;
  logic                clr_valid_en;
  logic [AW-1:0]       clr_valid_addr;
  logic [AW-1:0]       wr_addr_hi;

  vrb_loader #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W),
    .BUS_W    (BUS_W)
  ) u_loader (
    .clk            (clk),
    .rst            (rst),
    .ld_valid       (bus.ld_valid),
    .ld_addr        (bus.ld_addr),
    .ld_data        (bus.ld_data),
    .ld_ready       (bus.ld_ready),
    .ld_done        (bus.ld_done),
    .commit_en      (commit_en),
    .commit_addr    (commit_addr),
    .commit_data    (commit_data),
    .clr_valid_en   (clr_valid_en),
    .clr_valid_addr (clr_valid_addr)
  );

  // Partner register of an even-aligned wide write.
  assign wr_addr_hi = bus.wr_addr | AW'(1);

  // Write merge: commit first, then direct write on top (direct data wins),
  // then the first-beat invalidate so a fresh fill always reads as pending.
  always_comb begin
    regs_d      = regs_q;
    reg_valid_d = reg_valid_q;
    wr_err_d    = 1'b0;
    if (commit_en) begin
      regs_d[commit_addr]      = commit_data;
      reg_valid_d[commit_addr] = 1'b1;
    end
    if (bus.wr_en) begin
      if (!bus.wr_wide) begin
        regs_d[bus.wr_addr]      = bus.wr_data[REG_W-1:0];
        reg_valid_d[bus.wr_addr] = 1'b1;
      end else if (!bus.wr_addr[0]) begin
        regs_d[bus.wr_addr]      = bus.wr_data[REG_W-1:0];
        regs_d[wr_addr_hi]       = bus.wr_data[2*REG_W-1:REG_W];
        reg_valid_d[bus.wr_addr] = 1'b1;
        reg_valid_d[wr_addr_hi]  = 1'b1;
      end else begin
        wr_err_d = 1'b1;
      end
    end
    if (clr_valid_en) begin
      reg_valid_d[clr_valid_addr] = 1'b0;
    end
  end

  // Register array, valid flags and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      reg_valid_q <= '1;
      wr_err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      reg_valid_q <= reg_valid_d;
      wr_err_q    <= wr_err_d;
    end
  end

  // Flatten the array onto the parallel read bus.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flatten
      assign bus.regs_out[gi*REG_W +: REG_W] = regs_q[gi];
    end
  endgenerate

  assign bus.reg_valid = reg_valid_q;
  assign bus.wr_err    = wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_register_bank
// Brief    : Self-checking bench for vector_register_bank (default geometry).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_register_bank;
  localparam int NR    = 4;
  localparam int RW    = 512;
  localparam int BW    = 64;
  localparam int BEATS = RW / BW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_register_bank_if #(.NUM_REGS(NR), .REG_W(RW), .BUS_W(BW)) bus ();

  vector_register_bank #(.NUM_REGS(NR), .REG_W(RW), .BUS_W(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: register contents and committed-data flags.
  logic [RW-1:0] m_regs [NR];
  logic [NR-1:0] m_valid;

  function automatic logic [RW-1:0] rand_reg();
    logic [RW-1:0] r;
    for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.wr_en    = 1'b0;
    bus.wr_wide  = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_valid = '1;
  endtask

  // Occasional narrow direct write to a random register while a fill runs.
  task automatic mid_write();
    int wa;
    logic [RW-1:0] d;
    if ($urandom_range(0, 2) == 0) begin
      wa = $urandom_range(0, NR - 1);
      d  = rand_reg();
      bus.wr_en   = 1'b1;
      bus.wr_wide = 1'b0;
      bus.wr_addr = wa[1:0];
      bus.wr_data = {rand_reg(), d};
      m_regs[wa]  = d;
      m_valid[wa] = 1'b1;
    end
  endtask

  // Runs one fill; abort_after>0 stops after that many beats (caller resets).
  task automatic do_load(input int addr, input int gap, input bit rnd_gap,
                         input bit fixed_data, input bit mid_writes,
                         input bit collide, input int abort_after);
    logic [BW-1:0] b [BEATS];
    logic [RW-1:0] expv;
    int g;
    int junk;
    for (int k = 0; k < BEATS; k++) begin
      b[k] = fixed_data ? BW'(k) : {$urandom, $urandom};
      expv[k*BW +: BW] = b[k];
    end
    for (int k = 0; k < BEATS; k++) begin
      if (k > 0) begin
        g = rnd_gap ? $urandom_range(0, 3) : gap;
        for (int j = 0; j < g; j++) begin
          if (mid_writes) mid_write();
          step();
          bus.wr_en = 1'b0;
          total++;
          if (bus.ld_ready !== 1'b1 || bus.ld_done !== 1'b0 || bus.reg_valid !== m_valid) begin
            bad++;
            $display("FAIL gap_state beat%0d: ready=%b done=%b valid=%b, want ready=1 done=0 valid=%b",
                     k, bus.ld_ready, bus.ld_done, bus.reg_valid, m_valid);
          end
        end
      end
      total++;
      if (bus.ld_ready !== 1'b1) begin
        bad++;
        $display("FAIL ld_ready_fill beat%0d: got %b want 1", k, bus.ld_ready);
      end
      bus.ld_valid = 1'b1;
      junk = $urandom_range(0, NR - 1);
      bus.ld_addr = (k == 0) ? addr[1:0] : junk[1:0];
      bus.ld_data = b[k];
      if (k > 0 && mid_writes) mid_write();
      step();
      bus.ld_valid = 1'b0;
      bus.wr_en    = 1'b0;
      if (k == 0) m_valid[addr] = 1'b0;
      total++;
      if (bus.reg_valid !== m_valid || bus.ld_done !== 1'b0) begin
        bad++;
        $display("FAIL fill_valid beat%0d: valid=%b done=%b, want valid=%b done=0",
                 k, bus.reg_valid, bus.ld_done, m_valid);
      end
      if (abort_after == k + 1) return;
    end
    // Commit cycle: the loader refuses beats.
    total++;
    if (bus.ld_ready !== 1'b0 || bus.ld_done !== 1'b0) begin
      bad++;
      $display("FAIL commit_cycle: ready=%b done=%b, want ready=0 done=0", bus.ld_ready, bus.ld_done);
    end
    if (collide) begin
      bus.wr_en   = 1'b1;
      bus.wr_wide = 1'b0;
      bus.wr_addr = addr[1:0];
      bus.wr_data = {rand_reg(), 512'hFF};
    end
    step();
    bus.wr_en = 1'b0;
    m_regs[addr]  = collide ? 512'hFF : expv;
    m_valid[addr] = 1'b1;
    total++;
    if (bus.ld_done !== 1'b1 || bus.ld_ready !== 1'b1 || bus.reg_valid !== m_valid) begin
      bad++;
      $display("FAIL load_done: done=%b ready=%b valid=%b, want done=1 ready=1 valid=%b",
               bus.ld_done, bus.ld_ready, bus.reg_valid, m_valid);
    end
    for (int i = 0; i < NR; i++) begin
      total++;
      if (bus.regs_out[i*RW +: RW] !== m_regs[i]) begin
        bad++;
        $display("FAIL load_data reg%0d: got %h want %h", i, bus.regs_out[i*RW +: RW], m_regs[i]);
      end
    end
    step();
    total++;
    if (bus.ld_done !== 1'b0) begin
      bad++;
      $display("FAIL ld_done_pulse: got %b want 0", bus.ld_done);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < NR; i++) begin
      total++;
      if (bus.regs_out[i*RW +: RW] !== '0) begin
        bad++;
        $display("FAIL reset_reg reg%0d: got %h want 0", i, bus.regs_out[i*RW +: RW]);
      end
    end
    total++;
    if (bus.reg_valid !== 4'b1111 || bus.ld_ready !== 1'b1 || bus.ld_done !== 1'b0 || bus.wr_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: valid=%b ready=%b done=%b err=%b, want 1111 1 0 0",
               bus.reg_valid, bus.ld_ready, bus.ld_done, bus.wr_err);
    end
  endtask

  task automatic test_narrow_write();
    bus.wr_en   = 1'b1;
    bus.wr_wide = 1'b0;
    bus.wr_addr = 2'd1;
    bus.wr_data = {rand_reg(), 512'hA5};
    step();
    bus.wr_en = 1'b0;
    m_regs[1] = 512'hA5;
    for (int i = 0; i < NR; i++) begin
      total++;
      if (bus.regs_out[i*RW +: RW] !== m_regs[i]) begin
        bad++;
        $display("FAIL narrow_write reg%0d: got %h want %h", i, bus.regs_out[i*RW +: RW], m_regs[i]);
      end
    end
  endtask

  task automatic test_wide_write();
    bus.wr_en   = 1'b1;
    bus.wr_wide = 1'b1;
    bus.wr_addr = 2'd2;
    bus.wr_data = {512'h22, 512'h11};
    step();
    m_regs[2] = 512'h11;
    m_regs[3] = 512'h22;
    total++;
    if (bus.wr_err !== 1'b0) begin
      bad++;
      $display("FAIL wide_even_err: got %b want 0", bus.wr_err);
    end
    bus.wr_addr = 2'd3;
    bus.wr_data = {rand_reg(), rand_reg()};
    step();
    bus.wr_en = 1'b0;
    total++;
    if (bus.wr_err !== 1'b1) begin
      bad++;
      $display("FAIL wide_odd_err: got %b want 1", bus.wr_err);
    end
    for (int i = 0; i < NR; i++) begin
      total++;
      if (bus.regs_out[i*RW +: RW] !== m_regs[i]) begin
        bad++;
        $display("FAIL wide_write reg%0d: got %h want %h", i, bus.regs_out[i*RW +: RW], m_regs[i]);
      end
    end
    step();
    total++;
    if (bus.wr_err !== 1'b0) begin
      bad++;
      $display("FAIL wr_err_pulse: got %b want 0", bus.wr_err);
    end
  endtask

  task automatic test_load_basic();
    do_load(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_load_gaps();
    do_load(0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_collision();
    do_load(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_rst_mid_fill();
    do_load(2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    total++;
    if (bus.regs_out[2*RW +: RW] !== '0 || bus.reg_valid !== 4'b1111 || bus.ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_fill: reg2=%h valid=%b ready=%b, want 0 1111 1",
               bus.regs_out[2*RW +: RW], bus.reg_valid, bus.ld_ready);
    end
    do_load(2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Random direct writes interleaved with random loads, gaps and mid-fill writes.
  task automatic test_random();
    int wa;
    int la;
    bit wide;
    bit exp_err;
    logic [RW-1:0] lo;
    logic [RW-1:0] hi;
    for (int it = 0; it < 20; it++) begin
      wa   = $urandom_range(0, NR - 1);
      wide = 1'($urandom_range(0, 1));
      lo   = rand_reg();
      hi   = rand_reg();
      bus.wr_en   = 1'b1;
      bus.wr_wide = wide;
      bus.wr_addr = wa[1:0];
      bus.wr_data = {hi, lo};
      step();
      bus.wr_en = 1'b0;
      exp_err = wide && (wa % 2 == 1);
      if (!wide) begin
        m_regs[wa] = lo;
        m_valid[wa] = 1'b1;
      end else if (!exp_err) begin
        m_regs[wa] = lo;
        m_regs[wa+1] = hi;
        m_valid[wa] = 1'b1;
        m_valid[wa+1] = 1'b1;
      end
      total++;
      if (bus.wr_err !== exp_err || bus.reg_valid !== m_valid) begin
        bad++;
        $display("FAIL rand_write it%0d: err=%b valid=%b, want err=%b valid=%b",
                 it, bus.wr_err, bus.reg_valid, exp_err, m_valid);
      end
      for (int i = 0; i < NR; i++) begin
        total++;
        if (bus.regs_out[i*RW +: RW] !== m_regs[i]) begin
          bad++;
          $display("FAIL rand_write_data it%0d reg%0d: got %h want %h", it, i, bus.regs_out[i*RW +: RW], m_regs[i]);
        end
      end
      la = $urandom_range(0, NR - 1);
      do_load(la, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_narrow_write();
    test_wide_write();
    test_load_basic();
    test_load_gaps();
    test_collision();
    test_rst_mid_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/vector_register_bank.md
# vector_register_bank

Parametrised successor to the four-entry 512-bit operand register file, feeding the same downstream lanes through parallel read outputs. Adds four things: configurable register count and width, single or even-aligned double-wide direct writes, a beat-serial load port with a valid/ready handshake that fills one register from a narrow bus, and per-register valid flags that track in-flight loads.

## Interface
- NUM_REGS, 4: number of registers; power of two, ≥2.
- REG_W, 512: register width in bits.
- BUS_W, 64: load-beat width; REG_W % BUS_W == 0; BEATS = REG_W/BUS_W ≥ 2.
- AW, $clog2(NUM_REGS): address width (derived).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  direct write strobe.
- wr_wide  in  1  with wr_en: write wr_data to regs wr_addr and wr_addr+1.
- wr_addr  in  AW  direct write target.
- wr_data  in  2*REG_W  low half → wr_addr; high half → wr_addr+1 (wide only).
- wr_err  out  1  registered one-cycle pulse: wide write with odd wr_addr was dropped.
- ld_valid  in  1  load beat present.
- ld_ready  out  1  loader can accept a beat.
- ld_addr  in  AW  target register; sampled on the first beat of a fill only.
- ld_data  in  BUS_W  beat payload, LSB-first.
- ld_done  out  1  registered one-cycle pulse: fill committed.
- reg_valid  out  NUM_REGS  bit i = register i holds committed data.
- regs_out  out  NUM_REGS*REG_W  register i at bits [i*REG_W +: REG_W].

## Operation
- Reset: all registers 0; reg_valid all 1s; ld_ready 1; ld_done 0; wr_err 0; loader IDLE; beat counter 0; shadow buffer 0.
- Direct write, wr_en=1, wr_wide=0: reg[wr_addr] ← wr_data[REG_W-1:0].
- Direct write, wr_en=1, wr_wide=1, wr_addr even: reg[wr_addr] ← low half; reg[wr_addr+1] ← high half.
- Direct write, wide with odd wr_addr: no register changes; wr_err pulses.
- A direct write sets reg_valid for each register it writes.
- Loader FSM:
  - IDLE: ld_ready=1. An accepted beat (ld_valid&&ld_ready) latches ld_addr and stores the beat in shadow[0 +: BUS_W]. It clears reg_valid[ld_addr], sets count=1 and moves to FILL.
  - FILL: ld_ready=1. Each accepted beat goes to shadow[count*BUS_W +: BUS_W] and count increments. On the beat with count==BEATS-1, go to COMMIT.
  - COMMIT: one cycle, ld_ready=0. At its closing edge: reg[target] ← shadow, reg_valid[target] ← 1, ld_done ← 1, count ← 0, go to IDLE.
- Gaps (ld_valid=0) in FILL hold state indefinitely; there is no timeout.
- Direct write and commit to the same register in the same edge: the direct write wins for the data. The commit still sets valid and pulses ld_done.
- A direct write to a register mid-fill updates it immediately and sets valid. The later commit overwrites that data.
- Direct writes to other registers are never blocked by the loader.
- rst mid-fill: fill abandoned, partial shadow discarded, all state returns to reset values.

## Timing
- Direct write: data and reg_valid visible on regs_out one cycle after the wr_en edge.
- Load, first beat accepted at edge t: last beat at edge t+BEATS-1 (no gaps), COMMIT occupies the following cycle.
- Register update, reg_valid set and ld_done high are all in the cycle after the COMMIT edge, i.e. visible after edge t+BEATS. ld_ready returns to 1 in that same cycle.
- Minimum fill-to-fill spacing: BEATS+1 cycles.
- reg_valid[target] reads 0 from the cycle after the first-beat edge until commit.
- All outputs are registered or pure decodes of registered state; there are no combinational paths from inputs to outputs.

## Structure
- Package vrb_pkg holds:
  - the loader state enum {IDLE, FILL, COMMIT};
  - the beats(REG_W, BUS_W) function;
  - an elaboration-time check function for the divisibility and power-of-two rules.
- Sub-module vrb_loader contains the FSM, beat counter, shadow buffer and target latch. It outputs commit_en, commit_addr, commit_data and clr_valid_en/addr.
- Top level: register array, write-priority merge, reg_valid, wr_err and output flattening.

## Test plan
All scenarios use the defaults: NUM_REGS=4, REG_W=512, BUS_W=64, BEATS=8.
- Reset, then idle: regs_out all 0, reg_valid=4'b1111, ld_ready=1. Then narrow write of 512'hA5 to addr 1 → reg1=0xA5 next cycle, others 0.
- Wide write to addr 2 with high half 0x22 and low half 0x11 → reg2=0x11, reg3=0x22. Wide write to addr 3 → no change, wr_err pulses exactly one cycle.
- Load to addr 0, beats 0x00..0x07 back-to-back:
  - reg_valid[0]=0 during the fill;
  - ld_ready=0 for exactly one cycle;
  - then reg0 = beats concatenated with beat 0 at the LSBs, ld_done pulses, reg_valid[0]=1.
- Load with ld_valid gaps of 3 cycles between beats → same final reg0; commit delayed by 7×3 cycles.
- Same-edge direct write of 0xFF to addr 0 and commit to addr 0 → reg0=0xFF, ld_done=1, reg_valid[0]=1.
- rst asserted after 4 beats of a load to addr 2 → reg2 unchanged (0), state IDLE. A new full load then commits correctly.
